// File: rtl/zorro_cycle_master.sv
// Zorro-style asynchronous bus cycle master: turns single-cycle requests into a
// handshaked AS/UDS/LDS bus cycle with DTACK/BERR termination and a timeout.
module zorro_cycle_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic [22:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [22:0] ADDR,
    output logic        AS_n,
    output logic        UDS_n,
    output logic        LDS_n,
    output logic        RW,
    output logic [15:0] DOUT,
    output logic        DOE,
    input  logic [15:0] DIN,
    input  logic        DTACK_n,
    input  logic        BERR_n
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAssert, StStrobe, StWait, StEnd, StHold
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          dtack_meta_q, dtack_s;
    logic          berr_meta_q, berr_s;
    logic [22:0]   addr_q;
    logic          wr_q;
    logic [1:0]    be_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rdata_q;
    logic          err_q, err_d;
    logic          bad_q, bad_d;
    logic          accept, capture;

    // State register, synchronisers and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            dtack_meta_q <= 1'b1;
            dtack_s      <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_s       <= 1'b1;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            be_q         <= 2'b00;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dtack_meta_q <= DTACK_n;
            dtack_s      <= dtack_meta_q;
            berr_meta_q  <= BERR_n;
            berr_s       <= berr_meta_q;
            err_q        <= err_d;
            bad_q        <= bad_d;
            if (accept) begin
                addr_q  <= req_addr;
                wr_q    <= req_wr;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
            if (capture) begin
                rdata_q <= DIN;
            end
        end
    end

    // Saturating increment; the timer must never wrap back to zero
    assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        bad_d   = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_be != 2'b00) begin
                        accept  = 1'b1;
                        state_d = StAddr;
                    end else begin
                        bad_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            StAddr:   state_d = StAssert;
            StAssert: state_d = StStrobe;
            StStrobe: begin
                state_d = StWait;
                timer_d = '0;
            end
            StWait: begin
                timer_d = timer_inc;
                if (!berr_s) begin
                    err_d   = 1'b1;
                    state_d = StEnd;
                end else if (!dtack_s) begin
                    err_d   = 1'b0;
                    capture = !wr_q;
                    state_d = StEnd;
                end else if (timer_q == TLast) begin
                    err_d   = 1'b1;
                    state_d = StEnd;
                end
            end
            StEnd: begin
                state_d = StHold;
                timer_d = '0;
            end
            StHold: begin
                timer_d = timer_inc;
                if ((dtack_s && berr_s) || timer_q == TLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic as_on, ds_on, cyc_on, drive_on;

    always_comb begin
        as_on    = (state_q == StAssert) || (state_q == StStrobe) || (state_q == StWait);
        // Reads drop data strobes with AS; writes wait one cycle after DOE
        ds_on    = wr_q ? ((state_q == StStrobe) || (state_q == StWait)) : as_on;
        cyc_on   = as_on || (state_q == StAddr) || (state_q == StEnd);
        drive_on = as_on || (state_q == StEnd);
        busy     = (state_q != StIdle);
        ack      = bad_q || (state_q == StEnd);
        err      = ack && err_q;
        AS_n     = !as_on;
        UDS_n    = !(ds_on && be_q[1]);
        LDS_n    = !(ds_on && be_q[0]);
        RW       = !(cyc_on && wr_q);
        DOE      = drive_on && wr_q;
        ADDR     = addr_q;
        DOUT     = wdata_q;
        rdata    = rdata_q;
    end

endmodule

// File: tb/tb_zorro_cycle_master.sv
// Directed bench for zorro_cycle_master: read, write, timeout, bus error,
// reset mid-cycle, illegal request and request-while-busy scenarios.
module tb_zorro_cycle_master;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req = 1'b0;
    logic [22:0] req_addr = '0;
    logic        req_wr = 1'b0;
    logic [1:0]  req_be = 2'b00;
    logic [15:0] req_wdata = '0;
    logic        busy, ack, err;
    logic [15:0] rdata;
    logic [22:0] ADDR;
    logic        AS_n, UDS_n, LDS_n, RW, DOE;
    logic [15:0] DOUT;
    logic [15:0] DIN = '0;
    logic        DTACK_n = 1'b1;
    logic        BERR_n = 1'b1;

    int checks = 0;
    int errors = 0;

    zorro_cycle_master #(.TIMEOUT(64)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req       (req),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .ADDR      (ADDR),
        .AS_n      (AS_n),
        .UDS_n     (UDS_n),
        .LDS_n     (LDS_n),
        .RW        (RW),
        .DOUT      (DOUT),
        .DOE       (DOE),
        .DIN       (DIN),
        .DTACK_n   (DTACK_n),
        .BERR_n    (BERR_n)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [22:0] a, input logic wr, input logic [1:0] be,
                         input logic [15:0] wd);
        req       = 1'b1;
        req_addr  = a;
        req_wr    = wr;
        req_be    = be;
        req_wdata = wd;
        step();
        req = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int max, output int cycles);
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < max) begin
            if (ack) seen = 1;
            else begin
                step();
                cycles++;
            end
        end
        check_value({tag, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check_value({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cnt;

        // Reset values
        steps(2);
        check_value("rst_strobes", {29'd0, AS_n, UDS_n, LDS_n}, 32'h7);
        check_value("rst_rw_doe", {30'd0, RW, DOE}, 32'h2);
        check_value("rst_ack_err_busy", {29'd0, ack, err, busy}, 32'h0);
        check_value("rst_addr", 32'(ADDR), 32'h0);
        check_value("rst_dout", 32'(DOUT), 32'h0);
        check_value("rst_rdata", 32'(rdata), 32'h0);
        RESET = 1'b0;
        steps(2);

        // Word read, DTACK three cycles after AS falls
        issue(23'h740000, 1'b0, 2'b11, 16'h0);
        check_value("rd_addr", 32'(ADDR), 32'h740000);
        check_value("rd_addr_phase", {29'd0, busy, RW, AS_n}, 32'h7);
        step();
        check_value("rd_strobes", {29'd0, AS_n, UDS_n, LDS_n}, 32'h0);
        steps(3);
        DTACK_n = 1'b0;
        DIN     = 16'hC000;
        wait_ack("rd", 20, cyc);
        check_value("rd_err", 32'(err), 32'd0);
        check_value("rd_rdata", 32'(rdata), 32'hC000);
        check_value("rd_end_strobes", {29'd0, AS_n, UDS_n, LDS_n}, 32'h7);
        DTACK_n = 1'b1;
        DIN     = 16'hFFFF;
        wait_idle("rd");
        check_value("rd_rdata_hold", 32'(rdata), 32'hC000);

        // Timeout read: ASSERT + STROBE + 64 WAIT cycles with AS low
        issue(23'h000100, 1'b0, 2'b11, 16'h0);
        cnt = 0;
        cyc = 0;
        while (!ack && cyc < 200) begin
            if (!AS_n) cnt++;
            step();
            cyc++;
        end
        check_value("to_as_low_cycles", 32'(cnt), 32'd66);
        check_value("to_ack", 32'(ack), 32'd1);
        check_value("to_err", 32'(err), 32'd1);
        check_value("to_rdata", 32'(rdata), 32'hC000);
        check_value("to_strobes", {29'd0, AS_n, UDS_n, LDS_n}, 32'h7);
        wait_idle("to");

        // Upper byte write with DTACK already asserted
        DTACK_n = 1'b0;
        steps(3);
        issue(23'h000200, 1'b1, 2'b10, 16'h8000);
        check_value("wr_addr_phase", {30'd0, RW, DOE}, 32'h0);
        step();
        check_value("wr_assert", {28'd0, AS_n, UDS_n, DOE, LDS_n}, 32'h7);
        check_value("wr_dout", 32'(DOUT), 32'h8000);
        step();
        check_value("wr_strobe", {29'd0, UDS_n, LDS_n, DOE}, 32'h3);
        wait_ack("wr", 20, cyc);
        check_value("wr_ack_latency", 32'(cyc), 32'd2);
        check_value("wr_end", {29'd0, err, DOE, LDS_n}, 32'h3);
        step();
        check_value("wr_hold", {30'd0, DOE, ack}, 32'h0);
        DTACK_n = 1'b1;
        wait_idle("wr");

        // DTACK and BERR together: bus error wins
        issue(23'h000300, 1'b0, 2'b11, 16'h0);
        step();
        DTACK_n = 1'b0;
        BERR_n  = 1'b0;
        DIN     = 16'h1234;
        wait_ack("be", 20, cyc);
        check_value("be_err", 32'(err), 32'd1);
        check_value("be_rdata", 32'(rdata), 32'hC000);
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
        wait_idle("be");

        // Reset during WAIT of a write
        issue(23'h000400, 1'b1, 2'b11, 16'hBEEF);
        steps(4);
        check_value("rw_pre", {30'd0, DOE, AS_n}, 32'h2);
        RESET = 1'b1;
        step();
        check_value("rw_strobes", {29'd0, AS_n, UDS_n, LDS_n}, 32'h7);
        check_value("rw_outs", {28'd0, DOE, busy, ack, RW}, 32'h1);
        check_value("rw_rdata", 32'(rdata), 32'h0);
        RESET = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (ack) cnt++;
            step();
        end
        check_value("rw_no_ack", 32'(cnt), 32'd0);
        DTACK_n = 1'b0;
        DIN     = 16'h5A5A;
        steps(3);
        issue(23'h000500, 1'b0, 2'b11, 16'h0);
        wait_ack("rw_rd", 20, cyc);
        check_value("rw_rd_err", 32'(err), 32'd0);
        check_value("rw_rd_rdata", 32'(rdata), 32'h5A5A);
        DTACK_n = 1'b1;
        wait_idle("rw_rd");

        // Illegal request with no byte enables
        issue(23'h000600, 1'b0, 2'b00, 16'h0);
        check_value("il_ack", {29'd0, ack, err, busy}, 32'h6);
        check_value("il_as", 32'(AS_n), 32'd1);
        step();
        check_value("il_one_pulse", {30'd0, ack, AS_n}, 32'h1);

        // Requests while busy are ignored: one cycle, one ack
        DTACK_n = 1'b0;
        steps(3);
        issue(23'h000700, 1'b0, 2'b01, 16'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack) begin
                cnt++;
                DTACK_n = 1'b1;
            end
            req      = busy;
            req_addr = 23'h7ABC;
            req_be   = 2'b11;
            step();
        end
        req = 1'b0;
        check_value("bz_ack_count", 32'(cnt), 32'd1);
        check_value("bz_addr", 32'(ADDR), 32'h700);
        check_value("bz_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zorro_cycle_master.md
ZORRO_CYCLE_MASTER -- requirements
Module: zorro_cycle_master

Interface
REQ-001 Parameter TIMEOUT, default 64: WAIT-state cycles before the block aborts a cycle with error.
REQ-002 CLK  in  1  7 MHz bus clock; all state changes on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 req  in  1  one-cycle request strobe, sampled in IDLE only.
REQ-005 req_addr  in  23  word address [23:1].
REQ-006 req_wr  in  1  1 = write, 0 = read.
REQ-007 req_be  in  2  byte enables, [1] = upper (UDS), [0] = lower (LDS).
REQ-008 req_wdata  in  16  write data.
REQ-009 busy  out  1  high from the cycle after accepting req until the cycle after returning to IDLE.
REQ-010 ack  out  1  one-cycle completion pulse.
REQ-011 err  out  1  valid with ack; 1 = bus error, timeout or illegal request.
REQ-012 rdata  out  16  read data, valid from ack onward until next read completes.
REQ-013 ADDR  out  23  bus address [23:1].
REQ-014 AS_n, UDS_n, LDS_n  out  1 each  active-low strobes.
REQ-015 RW  out  1  1 = read.
REQ-016 DOUT  out  16  write data; DOE  out  1  data bus drive enable.
REQ-017 DIN  in  16  bus data; DTACK_n, BERR_n  in  1 each  asynchronous bus responses.

Function
REQ-018 DTACK_n and BERR_n SHALL pass through two-flop synchronisers (reset value 1); only synchronised values (dtack_s, berr_s) affect control.
REQ-019 States: IDLE, ADDR, ASSERT, STROBE, WAIT, END, HOLD.
REQ-020 IDLE: on req=1 with req_be≠0, latch request fields and go to ADDR; with req_be=0, pulse ack with err=1 the next cycle, no bus activity, and stay IDLE.
REQ-021 ADDR (1 cycle): drive ADDR and RW from the latched request; strobes negated.
REQ-022 ASSERT (1 cycle): AS_n=0; reads assert the enabled UDS_n/LDS_n; writes set DOE=1 and drive DOUT.
REQ-023 STROBE (1 cycle): writes assert the enabled data strobes; reads hold their strobes.
REQ-024 WAIT: clear the timer on entry and increment it each cycle; exit when berr_s=0, dtack_s=0, or timer reaches TIMEOUT-1.
REQ-025 WAIT priority: berr_s=0 beats dtack_s=0, and dtack_s=0 beats timeout; berr_s or timeout sets err=1; dtack_s sets err=0.
REQ-026 On a DTACK exit during a read, rdata SHALL capture DIN on the WAIT->END edge; on an error exit, rdata is unchanged.
REQ-027 END (1 cycle): negate AS_n, UDS_n, LDS_n; ack=1 with err; DOE stays 1 for writes to provide data hold.
REQ-028 HOLD: DOE=0; return to IDLE once dtack_s=1 and berr_s=1, or after TIMEOUT cycles, whichever comes first.
REQ-029 req while busy=1 SHALL be ignored; no queueing.
REQ-030 Bus latency: AS_n low on the 2nd edge after req; minimum request-to-ack of 6 cycles, or 4 cycles with DTACK_n already low.
REQ-031 The timer SHALL be sized as clog2(TIMEOUT)+1 bits and SHALL saturate, never wrap.

Reset
REQ-032 RESET=1 SHALL force IDLE on the next edge, regardless of state, including mid-WAIT.
REQ-033 Reset values: AS_n=UDS_n=LDS_n=1, RW=1, DOE=0, DOUT=0, ADDR=0, ack=0, err=0, busy=0, rdata=0, synchroniser flops=1.
REQ-034 A cycle interrupted by reset SHALL NOT produce ack.

Verification
REQ-035 Word read, addr 0x740000 (byte 0xE80000), be=11, DTACK_n low 3 cycles after AS_n falls, DIN=0xC000 -> UDS_n=LDS_n=0, ack with err=0, rdata=0xC000.
REQ-036 Byte write, be=10, wdata=0x8000, prompt DTACK_n -> RW=0, DOE=1 one cycle before UDS_n falls, LDS_n stays 1, DOE falls in HOLD, ack with err=0.
REQ-037 No DTACK_n, TIMEOUT=64 -> exactly 64 WAIT cycles, then ack with err=1, rdata unchanged, strobes negated.
REQ-038 DTACK_n and BERR_n low on the same edge -> err=1, rdata unchanged.
REQ-039 RESET during WAIT -> all strobes high and DOE=0 next edge, no ack; a following read completes normally.
REQ-040 req with be=00 -> ack with err=1 one cycle later, AS_n never asserted; a second req while busy -> ignored, exactly one ack.
